// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Build with UART_PARITY_EN defined to add the parity state.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam logic        LINE_IDLE            = 1'b1;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} tx_state_t;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_t;
`endif

    // ceil(log2(n)), never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return ($clog2(n) > 0) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and ticks on the last count.
// Held at zero while clear is high so each frame starts phase-aligned.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned      CntW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q + CntW'(1);
        if (clear || (count_q == CntMax)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = !clear && (count_q == CntMax);

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: start, LSB-first data, optional parity, stop.
// Define UART_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 baud_tick
);

    localparam int unsigned      IdxW     = $clog2(DATA_BITS);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);
    localparam logic             StopLast = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("CLKS_PER_BIT must be at least 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
        $error("DATA_BITS must be in 5..9");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity
        $error("PARITY_ODD must be 0 or 1");
    end

    tx_state_t            state_d, state_q;
    logic [DATA_BITS-1:0] shreg_d, shreg_q;
    logic [IdxW-1:0]      idx_d, idx_q;
    logic                 stop_d, stop_q;
    logic                 serial_d, serial_q;
    logic                 ready_d, ready_q;
    logic                 busy_d, busy_q;
`ifdef UART_PARITY_EN
    logic                 parity_d, parity_q;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == StIdle),
        .tick (baud_tick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        serial_d = serial_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
`ifdef UART_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (tx_valid && ready_q) begin
                    state_d  = StStart;
                    shreg_d  = tx_data;
                    serial_d = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
`ifdef UART_PARITY_EN
                    parity_d = (^tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            StStart: begin
                if (baud_tick) begin
                    state_d  = StData;
                    idx_d    = '0;
                    serial_d = shreg_q[0];
                end
            end
            StData: begin
                if (baud_tick) begin
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + IdxW'(1);
                    if (idx_q == IdxLast) begin
`ifdef UART_PARITY_EN
                        state_d  = StParity;
                        serial_d = parity_q;
`else
                        state_d  = StStop;
                        serial_d = LINE_IDLE;
                        stop_d   = 1'b0;
`endif
                    end else begin
                        serial_d = shreg_q[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (baud_tick) begin
                    state_d  = StStop;
                    serial_d = LINE_IDLE;
                    stop_d   = 1'b0;
                end
            end
`endif
            StStop: begin
                if (baud_tick) begin
                    if (stop_q == StopLast) begin
                        state_d = StIdle;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            serial_q <= LINE_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
`ifdef UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Decoded from flops only: the final stop tick is the last cycle of the frame
    assign tx_done   = (state_q == StStop) && baud_tick && (stop_q == StopLast);
    assign tx_serial = serial_q;
    assign tx_ready  = ready_q;
    assign tx_busy   = busy_q;

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
- Transmit-side controller for the RS-422 serial link: owns and sequences a baud tick divider and drives one UART frame per accepted byte.
- Frame order: start, data LSB-first, optional parity, stop.
- Sits between the byte-level host interface (valid/ready) and the RS-422 line driver input (tx_serial).
- Replaces free-running delay-based tick generation with a clock-synchronous divider that restarts on every frame, so bit edges are phase-aligned to frame start.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per bit (100 MHz / 115200). Legal range ≥2.
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- STOP_BITS, 1: stop bits per frame. Legal values 1 or 2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Used only when UART_PARITY_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tx_data  in  DATA_BITS  byte to send; sampled only on handshake
- tx_valid  in  1  host has data
- tx_ready  out  1  sequencer can accept
- tx_serial  out  1  serial line output; idle high
- tx_busy  out  1  frame in progress
- tx_done  out  1  one-cycle pulse at frame completion
- baud_tick  out  1  divider tick, exposed for observability/debug

Behaviour:
- Reset values, registered and applied on the first rising clk with rst=1:
  - tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, baud_tick=0.
  - State = IDLE, divider count = 0.
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- Handshake:
  - A transfer occurs on a cycle with tx_valid && tx_ready.
  - tx_ready is high only in IDLE.
  - tx_data is latched into a shift register on the handshake cycle. Later changes to tx_data are ignored.
- Latency:
  - In the cycle after the handshake, tx_serial=0, tx_busy=1, tx_ready=0, state=START.
  - The divider is cleared to 0 in that same cycle.
- Divider:
  - Counts 0..CLKS_PER_BIT-1.
  - baud_tick=1 in the cycle where count==CLKS_PER_BIT-1, then wraps to 0.
  - Counter width is ceil(log2(CLKS_PER_BIT)).
  - Held at 0 in IDLE; baud_tick is never asserted in IDLE.
- Bit timing: every bit is held for exactly CLKS_PER_BIT cycles. State advances on baud_tick.
- Transitions:
  - START →(tick) DATA, with bit index 0.
  - DATA: on each tick, shift right and increment index. After bit DATA_BITS-1, go to PARITY if the macro is defined, else STOP.
  - PARITY →(tick) STOP.
  - STOP lasts STOP_BITS ticks with tx_serial=1, then → IDLE.
- Completion:
  - On the final STOP tick cycle, tx_done=1 for one cycle.
  - The next cycle shows IDLE, tx_ready=1, tx_busy=0.
- Frame length:
  - Without parity: (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles, i.e. 8680 for 8N1 at 868.
  - Add CLKS_PER_BIT cycles with parity.
- Back-to-back frames: with tx_valid held high, exactly one idle-high clk cycle separates the last stop-bit cycle from the next start bit (the handshake cycle).
- Reset mid-frame: the next cycle returns to the reset values. No tx_done pulse, and the partial frame is abandoned.
- tx_valid deasserted while busy: no effect.

Optional Feature:
- UART_PARITY_EN defined:
  - A PARITY state is inserted after DATA.
  - The parity bit is the XOR of the latched data bits, XOR PARITY_ODD. It is computed at the handshake and stored.
- Undefined: no PARITY state and no parity register; the frame goes DATA → STOP.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum typedef (tx_state_t);
  - the localparams DEFAULT_CLKS_PER_BIT=868 and LINE_IDLE=1'b1;
  - a function for counter width.
- One sub-module, uart_baud_tick.
  - Ports: clk, rst, clear, tick.
  - Parameter: CLKS_PER_BIT.
  - It is the divider instantiated by the sequencer.
- The sequencer keeps the FSM, shift register, bit index and parity logic.

Test Plan:
All scenarios use CLKS_PER_BIT=4, DATA_BITS=8 and STOP_BITS=1 unless stated.
1. Reset then idle: after rst, tx_serial=1, tx_ready=1, and baud_tick stays 0 for 50 cycles.
2. Single byte 0xA5:
   - Line shows 0 then bits 1,0,1,0,0,1,0,1, then 1, each held 4 cycles.
   - Start bit appears one cycle after the handshake.
   - tx_done pulses once, 40 cycles after start-bit onset minus 1.
3. Back-to-back 0x00 then 0xFF with tx_valid held: exactly one idle-high cycle between frames; 81 cycles from first start to second done.
4. Mid-frame reset during data bit 3 of 0x3C: tx_serial=1 on the next cycle, no tx_done, and the next byte 0x55 transmits correctly.
5. Data change while busy: handshake with 0x12, then drive tx_data=0xFF during the frame; the line still shows 0x12.
6. With UART_PARITY_EN and PARITY_ODD=0, send 0x07 (three ones):
   - Parity bit is 1 and the frame is 44 cycles.
   - With PARITY_ODD=1, the parity bit is 0.
